// File: rtl/fifo_stream_reader_if.sv
// ============================================================================
// fifo_stream_reader_if : FIFO read-port and output-stream bundle.
// Revision 1.0. Optional m_parity under FIFO_RD_PARITY_EN.
// ============================================================================
`default_nettype none

interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic [1:0]            buf_level;
`ifdef FIFO_RD_PARITY_EN
    logic                  m_parity;

    modport master (
        input  en, fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last, buf_level, m_parity
    );

    modport slave (
        output en, fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last, buf_level, m_parity
    );
`else
    modport master (
        input  en, fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last, buf_level
    );

    modport slave (
        output en, fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last, buf_level
    );
`endif
endinterface

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// fifo_stream_reader : drains a registered-read FIFO into a framed valid/ready
// stream through a 3-entry buffer. Optional macro: FIFO_RD_PARITY_EN.
// Revision 1.0.
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  wire logic            rd_clk,
    input  wire logic            rst,
    fifo_stream_reader_if.master bus
);

    localparam int              BEAT_W       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(PKT_LEN - 1);
    localparam logic [1:0]      C_PTR_LAST   = 2'd2;
    localparam logic [2:0]      C_DEPTH      = 3'd3;

    logic [DATA_WIDTH-1:0] r_mem [3];
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic [1:0]            r_count;
    logic                  r_inflight;
    logic [BEAT_W-1:0]     r_beat;

    logic                  w_issue;
    logic                  w_valid;
    logic                  w_pop;
    logic [2:0]            w_occupancy;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == C_PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Reserving a slot for the in-flight read keeps the buffer from ever
    // overflowing without looking at m_ready combinationally.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_issue     = bus.en && !bus.fifo_empty && (w_occupancy < C_DEPTH) && !rst;
    assign w_valid     = (r_count != 2'd0);
    assign w_pop       = w_valid && bus.m_ready;

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= 2'd0;
            r_tail <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_mem[r_tail] <= bus.fifo_dout;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
        end else begin
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (w_pop) begin
            r_beat <= (r_beat == C_LAST_BEAT) ? '0 : r_beat + 1'b1;
        end
    end

`ifdef FIFO_RD_PARITY_EN
    logic r_par [3];

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_par[i] <= 1'b0;
            end
        end else if (r_inflight) begin
            r_par[r_tail] <= ^bus.fifo_dout;
        end
    end

    assign bus.m_parity = r_par[r_head];
`endif

    assign bus.fifo_rd_en = w_issue;
    assign bus.m_data     = r_mem[r_head];
    assign bus.m_valid    = w_valid;
    assign bus.m_last     = w_valid && (r_beat == C_LAST_BEAT);
    assign bus.buf_level  = r_count;

endmodule

`default_nettype wire
